// File: rtl/multi_timer_pkg.sv
// Shared constants for the multi-channel timer: control register layout,
// mode encoding, write-address codes and prescaler sizing.
package multi_timer_pkg;

    localparam int CTRL_W        = 6;
    localparam int CTRL_EN       = 0;
    localparam int CTRL_MODE     = 1;
    localparam int CTRL_PSEL_LSB = 2;
    localparam int PSEL_W        = 3;
    localparam int CTRL_IE       = 5;

    localparam int PRESC_W = 7;

    localparam logic ADDR_CTRL   = 1'b0;
    localparam logic ADDR_RELOAD = 1'b1;

    typedef enum logic {
        MODE_PERIODIC = 1'b0,
        MODE_ONESHOT  = 1'b1
    } mode_e;

    // Low PSEL bits set: the prescaler strobes when all of them are ones.
    function automatic logic [PRESC_W-1:0] presc_mask(input logic [PSEL_W-1:0] psel);
        logic [PRESC_W-1:0] m;
        for (int i = 0; i < PRESC_W; i++) begin
            m[i] = (i < int'(psel));
        end
        return m;
    endfunction

endpackage

// File: rtl/timer_channel.sv
// One timer channel: control/reload registers, free-running prescaler,
// down-counter with reload or one-shot stop, tick pulse and sticky irq.
module timer_channel
    import multi_timer_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ctrl_we,
    input  logic             reload_we,
    input  logic [CNT_W-1:0] wr_data,
    input  logic             irq_ack,
    output logic             irq,
    output logic             tick,
    output logic [CNT_W-1:0] count
);

    logic [CTRL_W-1:0]  ctrl;
    logic [CNT_W-1:0]   reload;
    logic [PRESC_W-1:0] presc;
    logic [PRESC_W-1:0] mask;
    logic               en;
    logic               ie;
    mode_e              mode;
    logic               strobe;
    logic               terminal;

    assign en   = ctrl[CTRL_EN];
    assign ie   = ctrl[CTRL_IE];
    assign mode = mode_e'(ctrl[CTRL_MODE]);
    assign mask = presc_mask(ctrl[CTRL_PSEL_LSB +: PSEL_W]);

    // A control write owns the cycle, so it also suppresses any strobe.
    assign strobe   = en && ((presc & mask) == mask);
    assign terminal = strobe && !ctrl_we && (count == '0);

    // NOTE: all state here is sequential, so every assignment is non-blocking;
    // later assignments in the block deliberately override earlier ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl   <= '0;
            reload <= '0;
            presc  <= '0;
            count  <= '0;
            tick   <= 1'b0;
            irq    <= 1'b0;
        end else begin
            tick <= terminal;

            if (reload_we) begin
                reload <= wr_data;
            end

            if (ctrl_we) begin
                ctrl  <= wr_data[CTRL_W-1:0];
                presc <= '0;
                if (!en && wr_data[CTRL_EN]) begin
                    count <= reload;
                end
            end else if (en) begin
                presc <= presc + 1'b1;
                if (strobe) begin
                    if (count != '0) begin
                        count <= count - 1'b1;
                    end else if (mode == MODE_ONESHOT) begin
                        ctrl[CTRL_EN] <= 1'b0;
                        presc         <= '0;
                    end else begin
                        count <= reload;
                    end
                end
            end

            if (terminal && ie) begin
                irq <= 1'b1;
            end else if (irq_ack) begin
                irq <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/multi_timer.sv
// Bank of NUM_CH independent timer channels sharing one register write port;
// writes addressed beyond the last channel match no channel and are dropped.
module multi_timer
    import multi_timer_pkg::*;
#(
    parameter  int NUM_CH = 3,
    parameter  int CNT_W  = 8,
    localparam int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [SEL_W-1:0]        wr_sel,
    input  logic                    wr_addr,
    input  logic [CNT_W-1:0]        wr_data,
    input  logic [NUM_CH-1:0]       irq_ack,
    output logic [NUM_CH-1:0]       irq,
    output logic [NUM_CH-1:0]       tick,
    output logic [NUM_CH*CNT_W-1:0] count
);

    for (genvar i = 0; i < NUM_CH; i++) begin : gen_ch
        logic sel_hit;

        assign sel_hit = wr_en && (wr_sel == SEL_W'(i));

        timer_channel #(
            .CNT_W(CNT_W)
        ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .ctrl_we  (sel_hit && (wr_addr == ADDR_CTRL)),
            .reload_we(sel_hit && (wr_addr == ADDR_RELOAD)),
            .wr_data  (wr_data),
            .irq_ack  (irq_ack[i]),
            .irq      (irq[i]),
            .tick     (tick[i]),
            .count    (count[i*CNT_W +: CNT_W])
        );
    end

endmodule

// File: doc/multi_timer.md
MULTI_TIMER -- requirements
Module: multi_timer

Interface
REQ-001 Parameter NUM_CH, default 3, number of independent timer channels (1..8).
REQ-002 Parameter CNT_W, default 8, counter/reload width in bits (8..16).
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-005 wr_en  input  1  register write strobe, one write per asserted cycle.
REQ-006 wr_sel  input  $clog2(NUM_CH) (min 1)  target channel index.
REQ-007 wr_addr  input  1  0 = control register, 1 = reload register.
REQ-008 wr_data  input  CNT_W  write data; control uses bits [5:0].
REQ-009 irq_ack  input  NUM_CH  per-channel pending-clear, level-sampled.
REQ-010 irq  output  NUM_CH  per-channel pending interrupt, registered level.
REQ-011 tick  output  NUM_CH  per-channel one-cycle terminal pulse, registered.
REQ-012 count  output  NUM_CH*CNT_W  flattened current counts, channel 0 in LSBs.

Function
REQ-013 Control fields SHALL be: bit0 EN, bit1 MODE (0 periodic, 1 one-shot), bits4:2 PSEL, bit5 IE.
REQ-014 Each channel SHALL own a 7-bit prescaler generating a strobe once every 2^PSEL cycles (PSEL=0: every cycle).
REQ-015 When EN=0 the prescaler SHALL hold at 0 and count SHALL hold its value.
REQ-016 A control write changing EN 0->1 SHALL load count<=reload and prescaler<=0 at that edge.
REQ-017 Any control write with EN=1 before and after SHALL reset the prescaler to 0 and leave count unchanged.
REQ-018 On a strobe with count!=0, count SHALL decrement by 1.
REQ-019 On a strobe with count==0 (terminal event), count SHALL load reload; period = (reload+1) strobes; reload=0 gives a terminal event every strobe.
REQ-020 On a terminal event, tick SHALL be high for exactly the following cycle.
REQ-021 On a terminal event with IE=1, irq SHALL set at the same edge that raises tick.
REQ-022 In one-shot mode a terminal event SHALL clear EN and leave count at 0 instead of reloading.
REQ-023 irq SHALL clear on the edge where irq_ack is high; a simultaneous terminal event with IE=1 SHALL win (irq stays 1).
REQ-024 Clearing IE SHALL NOT clear an already-pending irq.
REQ-025 A reload write SHALL NOT disturb a running count; the new value applies at the next load.
REQ-026 A write with wr_sel >= NUM_CH SHALL be ignored.
REQ-027 Channels SHALL be fully independent; simultaneous events on several channels SHALL all be reported in the same cycle.

Reset
REQ-028 Reset SHALL clear control, reload, count, prescaler, irq and tick of every channel to 0, asynchronously.
REQ-029 Reset asserted mid-count SHALL abort the count; after release no tick or irq SHALL occur until EN is rewritten.

Structure
REQ-030 Package multi_timer_pkg SHALL hold control bit positions, the MODE encoding (periodic/one-shot), wr_addr codes and the prescaler width constant.
REQ-031 One sub-module timer_channel SHALL implement a single channel (registers, prescaler, counter, irq), instantiated NUM_CH times via generate.

Verification
REQ-032 Reload=3, PSEL=0, IE=1, periodic, EN written at edge t -> tick high in cycles after edges t+4, t+8, t+12; irq set after t+4.
REQ-033 Reload=2, PSEL=2, one-shot -> single tick 12 cycles after enable; EN reads 0; count stays 0; no further ticks over 100 cycles.
REQ-034 irq pending, irq_ack held high in the same cycle as a new terminal event -> irq remains 1; ack one cycle later -> irq 0.
REQ-035 Channel 0 running with reload=5; write reload=1 mid-count -> current period still 6 strobes, subsequent periods 2 strobes.
REQ-036 NUM_CH=3, all channels reload=0, PSEL=0 -> tick[2:0]=3'b111 every cycle; write with wr_sel=3 -> no register changes.
REQ-037 Reset pulsed asynchronously between clock edges mid-count -> all outputs 0 immediately; no tick after release until EN is rewritten.
